// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//
// Free-running raster timing generator for 800x600 @ 60 Hz on a 40 MHz pixel
// clock. It produces the count/sync/blank bundle that feeds the first stage of
// the overlay pipeline, plus a one-cycle frame_start pulse at pixel (0,0).
//
// Ports
//    clk          in   pixel clock, rising edge
//    rst          in   asynchronous reset, active-low (0 = reset)
//    hcount_out   out  [10:0] current pixel column, 0..H_TOTAL-1
//    hsync_out    out  horizontal sync, active level given by SYNC_POL
//    hblnk_out    out  1 while hcount_out >= H_VISIBLE
//    vcount_out   out  [10:0] current line, 0..V_TOTAL-1
//    vsync_out    out  vertical sync, active level given by SYNC_POL
//    vblnk_out    out  1 while vcount_out >= V_VISIBLE
//    frame_start  out  one-cycle pulse when the counters wrap to (0,0)
//
// Every output is a flop. Flags are decoded from the next-state counts and
// registered in the same edge as the counts, so each flag lines up exactly
// with the hcount_out/vcount_out presented alongside it. Both totals must fit
// in the 11-bit counters (<= 2048).
// -----------------------------------------------------------------------------
module vga_timing #(
   parameter int H_VISIBLE = 800,
   parameter int H_FRONT   = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BACK    = 88,
   parameter int V_VISIBLE = 600,
   parameter int V_FRONT   = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BACK    = 23,
   parameter bit SYNC_POL  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] hcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic [10:0] vcount_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic        frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_VIS        = 11'(H_VISIBLE);
   localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);

   localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
   localparam logic [10:0] V_VIS        = 11'(V_VISIBLE);
   localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [10:0] hCount_q, hCount_d;
   logic [10:0] vCount_q, vCount_d;
   logic        hSync_q, hSync_d;
   logic        vSync_q, vSync_d;
   logic        hBlnk_q, hBlnk_d;
   logic        vBlnk_q, vBlnk_d;
   logic        frameStart_q, frameStart_d;
   logic        hWrap;

   // Next-state counts and the flags decoded from them. Decoding the next
   // counts (rather than the current ones) is what lets the flags land in the
   // same register stage as the counts with zero skew. The line counter only
   // moves on the cycle the pixel counter wraps, so vsync/vblnk edges always
   // coincide with hcount_out = 0.
   always_comb begin
      hWrap        = (hCount_q == H_LAST);
      hCount_d     = hWrap ? 11'd0 : hCount_q + 11'd1;
      vCount_d     = vCount_q;
      if (hWrap) begin
         vCount_d  = (vCount_q == V_LAST) ? 11'd0 : vCount_q + 11'd1;
      end
      hBlnk_d      = (hCount_d >= H_VIS);
      vBlnk_d      = (vCount_d >= V_VIS);
      hSync_d      = ((hCount_d >= H_SYNC_START) && (hCount_d < H_SYNC_END))
                     ? SYNC_POL : ~SYNC_POL;
      vSync_d      = ((vCount_d >= V_SYNC_START) && (vCount_d < V_SYNC_END))
                     ? SYNC_POL : ~SYNC_POL;
      frameStart_d = hWrap && (vCount_q == V_LAST);
   end

   // Single register stage for the whole bundle. Reset parks the raster at
   // (0,0) with syncs inactive; the reset state itself is not a frame start,
   // so the first pulse only appears at the first natural wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hCount_q     <= 11'd0;
         vCount_q     <= 11'd0;
         hSync_q      <= ~SYNC_POL;
         vSync_q      <= ~SYNC_POL;
         hBlnk_q      <= 1'b0;
         vBlnk_q      <= 1'b0;
         frameStart_q <= 1'b0;
      end else begin
         hCount_q     <= hCount_d;
         vCount_q     <= vCount_d;
         hSync_q      <= hSync_d;
         vSync_q      <= vSync_d;
         hBlnk_q      <= hBlnk_d;
         vBlnk_q      <= vBlnk_d;
         frameStart_q <= frameStart_d;
      end
   end

   assign hcount_out  = hCount_q;
   assign vcount_out  = vCount_q;
   assign hsync_out   = hSync_q;
   assign vsync_out   = vSync_q;
   assign hblnk_out   = hBlnk_q;
   assign vblnk_out   = vBlnk_q;
   assign frame_start = frameStart_q;

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
//
// Directed bench for vga_timing. The full 800x600 instance covers reset,
// line wrap, hsync and mid-frame async reset. Two reduced-geometry instances
// (25 pixels x 16 lines, 400 cycles per frame, one per sync polarity) cover
// frame wrap, frame_start, vblank and vsync, since a full frame is far longer
// than a practical run.
//
// Reduced geometry: H 16/2/4/3 (total 25), V 10/1/2/3 (total 16)
//    hsync active on h 18..21, vblank on lines 10..15, vsync on lines 11..12
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_timing;

   logic        clk;
   logic        rst;

   logic [10:0] hCount, vCount;
   logic        hSync, vSync, hBlnk, vBlnk, frameStart;

   logic [10:0] pHCount, pVCount;
   logic        pHSync, pVSync, pHBlnk, pVBlnk, pFrameStart;

   logic [10:0] nHCount, nVCount;
   logic        nHSync, nVSync, nHBlnk, nVBlnk, nFrameStart;

   int checks   = 0;
   int failures = 0;
   int k        = 0;

   vga_timing dut (
      .clk         (clk),
      .rst         (rst),
      .hcount_out  (hCount),
      .hsync_out   (hSync),
      .hblnk_out   (hBlnk),
      .vcount_out  (vCount),
      .vsync_out   (vSync),
      .vblnk_out   (vBlnk),
      .frame_start (frameStart)
   );

   vga_timing #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
      .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
      .SYNC_POL(1'b1)
   ) dutSmallPos (
      .clk         (clk),
      .rst         (rst),
      .hcount_out  (pHCount),
      .hsync_out   (pHSync),
      .hblnk_out   (pHBlnk),
      .vcount_out  (pVCount),
      .vsync_out   (pVSync),
      .vblnk_out   (pVBlnk),
      .frame_start (pFrameStart)
   );

   vga_timing #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
      .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
      .SYNC_POL(1'b0)
   ) dutSmallNeg (
      .clk         (clk),
      .rst         (rst),
      .hcount_out  (nHCount),
      .hsync_out   (nHSync),
      .hblnk_out   (nHBlnk),
      .vcount_out  (nVCount),
      .vsync_out   (nVSync),
      .vblnk_out   (nVBlnk),
      .frame_start (nFrameStart)
   );

   // 40 MHz pixel clock; outputs are sampled on the falling edge.
   initial clk = 1'b0;
   always #12.5 clk = ~clk;

   // Advance to the next falling edge; k is the number of rising edges since
   // the most recent reset release.
   task stepCycle;
      @(negedge clk);
      k++;
   endtask

   task test_reset;
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (hCount !== 11'd0 || vCount !== 11'd0) begin
         failures++;
         $display("[TB] FAIL reset_counts: got h=%0d v=%0d, want h=0 v=0", hCount, vCount);
      end
      checks++;
      if ({hSync, vSync, hBlnk, vBlnk, frameStart} !== 5'b00000) begin
         failures++;
         $display("[TB] FAIL reset_flags_pos: got hs/vs/hb/vb/fs=%b, want 00000",
                  {hSync, vSync, hBlnk, vBlnk, frameStart});
      end
      checks++;
      if ({nHSync, nVSync} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL reset_syncs_neg: got hs/vs=%b, want 11", {nHSync, nVSync});
      end
      rst = 1'b1;
      k   = 0;
      stepCycle();
      checks++;
      if (hCount !== 11'd1 || vCount !== 11'd0) begin
         failures++;
         $display("[TB] FAIL release_first_edge: got h=%0d v=%0d, want h=1 v=0", hCount, vCount);
      end
   endtask

   task test_line_wrap;
      int blankCount;
      blankCount = 0;
      for (int i = 2; i <= 1057; i++) begin
         stepCycle();
         if (hBlnk === 1'b1) blankCount++;
         if (k == 799) begin
            checks++;
            if (hBlnk !== 1'b0) begin
               failures++;
               $display("[TB] FAIL hblnk_at_799: got %b, want 0", hBlnk);
            end
         end
         if (k == 800) begin
            checks++;
            if (hBlnk !== 1'b1 || hCount !== 11'd800) begin
               failures++;
               $display("[TB] FAIL hblnk_at_800: got hb=%b h=%0d, want hb=1 h=800", hBlnk, hCount);
            end
         end
         if (k == 1055) begin
            checks++;
            if (hCount !== 11'd1055 || vCount !== 11'd0 || hBlnk !== 1'b1) begin
               failures++;
               $display("[TB] FAIL line_end: got h=%0d v=%0d hb=%b, want h=1055 v=0 hb=1",
                        hCount, vCount, hBlnk);
            end
         end
         if (k == 1056) begin
            checks++;
            if (hCount !== 11'd0 || vCount !== 11'd1 || hBlnk !== 1'b0 || vBlnk !== 1'b0) begin
               failures++;
               $display("[TB] FAIL line_wrap: got h=%0d v=%0d hb=%b vb=%b, want h=0 v=1 hb=0 vb=0",
                        hCount, vCount, hBlnk, vBlnk);
            end
         end
      end
      checks++;
      if (blankCount != 256) begin
         failures++;
         $display("[TB] FAIL hblnk_cycles: got %0d, want 256", blankCount);
      end
   endtask

   task test_hsync;
      int activeCount;
      int firstH;
      int lastH;
      activeCount = 0;
      firstH      = -1;
      lastH       = -1;
      for (int i = 0; i < 1056; i++) begin
         stepCycle();
         if (hSync === 1'b1) begin
            activeCount++;
            if (firstH < 0) firstH = k % 1056;
            lastH = k % 1056;
         end
      end
      checks++;
      if (activeCount != 128) begin
         failures++;
         $display("[TB] FAIL hsync_width: got %0d, want 128", activeCount);
      end
      checks++;
      if (firstH != 840 || lastH != 967) begin
         failures++;
         $display("[TB] FAIL hsync_window: got first=%0d last=%0d, want first=840 last=967",
                  firstH, lastH);
      end
      checks++;
      if (frameStart !== 1'b0 || vCount !== 11'd2) begin
         failures++;
         $display("[TB] FAIL full_no_frame_yet: got fs=%b v=%0d, want fs=0 v=2", frameStart, vCount);
      end
   endtask

   task test_frame_wrap;
      int pulses;
      int pulseAligned;
      int blankCycles;
      pulses       = 0;
      pulseAligned = 0;
      blankCycles  = 0;
      for (int i = 0; i < 400; i++) begin
         stepCycle();
         if (pFrameStart === 1'b1) begin
            pulses++;
            if (k % 400 == 0) pulseAligned++;
         end
         if (pVBlnk === 1'b1) blankCycles++;
         if (k % 400 == 399) begin
            checks++;
            if (pHCount !== 11'd24 || pVCount !== 11'd15 || pFrameStart !== 1'b0) begin
               failures++;
               $display("[TB] FAIL frame_last_pixel: got h=%0d v=%0d fs=%b, want h=24 v=15 fs=0",
                        pHCount, pVCount, pFrameStart);
            end
         end
         if (k % 400 == 0) begin
            checks++;
            if (pHCount !== 11'd0 || pVCount !== 11'd0 || pFrameStart !== 1'b1) begin
               failures++;
               $display("[TB] FAIL frame_wrap: got h=%0d v=%0d fs=%b, want h=0 v=0 fs=1",
                        pHCount, pVCount, pFrameStart);
            end
         end
      end
      checks++;
      if (pulses != 1 || pulseAligned != 1) begin
         failures++;
         $display("[TB] FAIL frame_start_count: got pulses=%0d aligned=%0d, want 1 and 1",
                  pulses, pulseAligned);
      end
      checks++;
      if (blankCycles != 150) begin
         failures++;
         $display("[TB] FAIL vblnk_cycles: got %0d, want 150", blankCycles);
      end
   endtask

   task test_vsync;
      int posActive;
      int negActive;
      int badEdges;
      int wrongLine;
      logic prevPos;
      logic prevNeg;
      posActive = 0;
      negActive = 0;
      badEdges  = 0;
      wrongLine = 0;
      prevPos   = pVSync;
      prevNeg   = nVSync;
      for (int i = 0; i < 400; i++) begin
         stepCycle();
         if (pVSync === 1'b1) begin
            posActive++;
            if (((k / 25) % 16) != 11 && ((k / 25) % 16) != 12) wrongLine++;
         end
         if (nVSync === 1'b0) negActive++;
         if ((pVSync !== prevPos || nVSync !== prevNeg) && (k % 25) != 0) badEdges++;
         prevPos = pVSync;
         prevNeg = nVSync;
      end
      checks++;
      if (posActive != 50 || wrongLine != 0) begin
         failures++;
         $display("[TB] FAIL vsync_pos: got active=%0d off_line=%0d, want 50 and 0",
                  posActive, wrongLine);
      end
      checks++;
      if (negActive != 50) begin
         failures++;
         $display("[TB] FAIL vsync_neg: got low cycles=%0d, want 50", negActive);
      end
      checks++;
      if (badEdges != 0) begin
         failures++;
         $display("[TB] FAIL vsync_edges: got %0d edges away from h=0, want 0", badEdges);
      end
   endtask

   task test_async_reset;
      // k = 5075: full raster at line 4 pixel 851 (inside hsync and hblank),
      // reduced raster at line 11 pixel 0 (inside vsync and vblank).
      while (k < 5075) stepCycle();
      checks++;
      if (hCount !== 11'd851 || vCount !== 11'd4 || hSync !== 1'b1 || hBlnk !== 1'b1) begin
         failures++;
         $display("[TB] FAIL pre_reset_full: got h=%0d v=%0d hs=%b hb=%b, want h=851 v=4 hs=1 hb=1",
                  hCount, vCount, hSync, hBlnk);
      end
      checks++;
      if (pVSync !== 1'b1 || pVBlnk !== 1'b1 || nVSync !== 1'b0 || pVCount !== 11'd11) begin
         failures++;
         $display("[TB] FAIL pre_reset_small: got pvs=%b pvb=%b nvs=%b pv=%0d, want 1 1 0 11",
                  pVSync, pVBlnk, nVSync, pVCount);
      end
      #3 rst = 1'b0;
      #1;
      checks++;
      if (hCount !== 11'd0 || vCount !== 11'd0 || hSync !== 1'b0 || hBlnk !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_reset_full: got h=%0d v=%0d hs=%b hb=%b, want 0 0 0 0",
                  hCount, vCount, hSync, hBlnk);
      end
      checks++;
      if (pVSync !== 1'b0 || pVBlnk !== 1'b0 || nVSync !== 1'b1 || nHSync !== 1'b1) begin
         failures++;
         $display("[TB] FAIL async_reset_small: got pvs=%b pvb=%b nvs=%b nhs=%b, want 0 0 1 1",
                  pVSync, pVBlnk, nVSync, nHSync);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (hCount !== 11'd0 || pHCount !== 11'd0) begin
         failures++;
         $display("[TB] FAIL held_in_reset: got h=%0d ph=%0d, want 0 0", hCount, pHCount);
      end
      rst = 1'b1;
      k   = 0;
      stepCycle();
      checks++;
      if (hCount !== 11'd1 || vCount !== 11'd0 || frameStart !== 1'b0) begin
         failures++;
         $display("[TB] FAIL restart_after_reset: got h=%0d v=%0d fs=%b, want h=1 v=0 fs=0",
                  hCount, vCount, frameStart);
      end
   endtask

   initial begin
      $display("[TB] vga_timing bench starting");
      test_reset();
      test_line_wrap();
      test_hsync();
      test_frame_wrap();
      test_vsync();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
